// File: rtl/mask_pkg.sv
// Shared definitions for the masked-gate randomness source: LFSR taps,
// default sizes and the source FSM state type.
package mask_pkg;

    localparam int LFSR_W_DEF   = 32;
    localparam int NUM_RAND_DEF = 9;
    localparam logic [LFSR_W_DEF-1:0] SEED_DEFAULT_DEF = 32'hACE1_2468;

    // Fibonacci feedback taps for the 32-bit polynomial
    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;
    localparam int TAP_D = 0;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } rng_state_t;

endpackage

// File: rtl/lfsr_advance.sv
// Purely combinational multi-step advance of the Fibonacci LFSR:
// applies STEPS single-bit shifts to state_in in one evaluation.
module lfsr_advance
    import mask_pkg::*;
#(
    parameter int W     = LFSR_W_DEF,
    parameter int STEPS = NUM_RAND_DEF
) (
    input  logic [W-1:0] state_in,
    output logic [W-1:0] state_out
);

    always_comb begin
        state_out = state_in;
        for (int i = 0; i < STEPS; i++) begin
            state_out = {state_out[W-2:0],
                         state_out[TAP_A] ^ state_out[TAP_B] ^
                         state_out[TAP_C] ^ state_out[TAP_D]};
        end
    end

endmodule

// File: rtl/mask_rand_source.sv
// Fresh-randomness source for the 2-share masked gate: seedable LFSR with
// warm-up, valid/ready output and optional repetition health test (MASK_RNG_HEALTH_EN).
module mask_rand_source
    import mask_pkg::*;
#(
    parameter int                NUM_RAND      = NUM_RAND_DEF,
    parameter int                LFSR_W        = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT  = SEED_DEFAULT_DEF,
    parameter int                WARMUP_CYCLES = 64,
    parameter int                REPEAT_LIMIT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_valid,
    input  logic [LFSR_W-1:0]   seed_data,
    output logic                seed_ready,
    input  logic                rnd_ready,
    output logic                rnd_valid,
    output logic [NUM_RAND-1:0] rnd,
    output logic                busy,
    output logic                health_fail
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // rnd_valid/seed_ready depend only on FSM state, never on the partner's ready/valid.

    localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] WARM_LAST =
        CNT_W'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    rng_state_t        state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_adv;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rnd_fire, seed_fire, health_trip;

    lfsr_advance #(
        .W     (LFSR_W),
        .STEPS (NUM_RAND)
    ) u_adv (
        .state_in  (lfsr_q),
        .state_out (lfsr_adv)
    );

    assign rnd_valid  = (state_q == RUN);
    assign busy       = (state_q == WARMUP);
    assign seed_ready = (state_q != WARMUP);
    assign rnd        = lfsr_q[NUM_RAND-1:0];
    assign rnd_fire   = rnd_valid & rnd_ready;
    assign seed_fire  = seed_valid & seed_ready;

`ifdef MASK_RNG_HEALTH_EN
    localparam int REP_W = $clog2(REPEAT_LIMIT + 1);

    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [NUM_RAND-1:0] prev_q, prev_d;
    logic                prev_vld_q, prev_vld_d;
    logic                health_q, health_d;

    // Count consecutive identical consumed words; a seed load restarts the test.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        health_d    = health_q;
        health_trip = 1'b0;
        if (seed_fire) begin
            rep_cnt_d  = '0;
            prev_vld_d = 1'b0;
            health_d   = 1'b0;
        end else if (rnd_fire) begin
            prev_d     = rnd;
            prev_vld_d = 1'b1;
            if (prev_vld_q && (rnd == prev_q)) begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
                rep_cnt_d = REP_W'(1);
            end
            if (rep_cnt_d == REP_W'(REPEAT_LIMIT)) begin
                health_trip = 1'b1;
                health_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q  <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            health_q   <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            health_q   <= health_d;
        end
    end

    assign health_fail = health_q;
`else
    assign health_trip = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        case (state_q)
            WARMUP: begin
                if (WARMUP_CYCLES == 0) begin
                    state_d = RUN;
                end else begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (rnd_fire) begin
                    lfsr_d = lfsr_adv;
                end
                if (health_trip) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
        // A seed load overrides any advance; zero would lock the LFSR, so it maps to the default.
        if (seed_fire) begin
            lfsr_d  = (seed_data == '0) ? SEED_DEFAULT : seed_data;
            cnt_d   = '0;
            state_d = WARMUP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARMUP;
            lfsr_q  <= SEED_DEFAULT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mask_rand_source.sv
// Directed bench for mask_rand_source: one default instance (64-cycle warm-up)
// and one with no warm-up, checked against a bench-side LFSR model.
module tb_mask_rand_source;

    localparam logic [31:0] SEED_DEF = 32'hACE1_2468;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_seed_valid, a_seed_ready, a_rnd_ready, a_rnd_valid, a_busy, a_health;
    logic [31:0] a_seed_data;
    logic [8:0]  a_rnd;
    logic        b_seed_valid, b_seed_ready, b_rnd_ready, b_rnd_valid, b_busy, b_health;
    logic [31:0] b_seed_data;
    logic [8:0]  b_rnd;

    mask_rand_source dut (
        .clk(clk), .rst(rst),
        .seed_valid(a_seed_valid), .seed_data(a_seed_data), .seed_ready(a_seed_ready),
        .rnd_ready(a_rnd_ready), .rnd_valid(a_rnd_valid), .rnd(a_rnd),
        .busy(a_busy), .health_fail(a_health)
    );

    mask_rand_source #(.WARMUP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .seed_valid(b_seed_valid), .seed_data(b_seed_data), .seed_ready(b_seed_ready),
        .rnd_ready(b_rnd_ready), .rnd_valid(b_rnd_valid), .rnd(b_rnd),
        .busy(b_busy), .health_fail(b_health)
    );

    // scoreboard
    int          checks = 0;
    int          failures = 0;
    logic [8:0]  exp_q[$];
    logic [31:0] m_a, m_b;
    logic [8:0]  cap0[1000];
    logic [8:0]  cap1[1000];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_step(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return {s[30:0], fb};
    endfunction

    function automatic logic [31:0] m_adv(input logic [31:0] s);
        logic [31:0] t;
        t = s;
        for (int k = 0; k < 9; k++) t = m_step(t);
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: consume n words from dut0 and score them against the model
    task automatic consume_b(input string tag, input int n, input int cap_sel);
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(m_b[8:0]);
            m_b = m_adv(m_b);
        end
        b_rnd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (b_rnd_valid !== 1'b1) begin
                check({tag, "_valid"}, 32'(b_rnd_valid), 32'd1);
                break;
            end
            e = exp_q.pop_front();
            check(tag, 32'(b_rnd), 32'(e));
            if (cap_sel == 1) cap0[i] = b_rnd;
            if (cap_sel == 2) cap1[i] = b_rnd;
            tick();
        end
        b_rnd_ready = 1'b0;
        exp_q.delete();
    endtask

    // driver: reseed dut0 (rnd_ready held low by caller)
    task automatic seed_b(input logic [31:0] data);
        int w;
        w = 0;
        while (b_seed_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        check("seed_ready", 32'(b_seed_ready), 32'd1);
        b_seed_valid = 1'b1;
        b_seed_data  = data;
        tick();
        b_seed_valid = 1'b0;
        check("seed_busy", 32'(b_busy), 32'd1);
        check("seed_health_clr", 32'(b_health), 32'd0);
        m_b = (data == 32'd0) ? SEED_DEF : data;
        w = 0;
        while (b_rnd_valid !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("seed_warm_cycles", 32'(w), 32'd1);
    endtask

    initial begin
        int w, busy_n, chg, same;
        logic [8:0] held;
        logic [8:0] w5[5];
        logic [8:0] e;

        a_seed_valid = 1'b0; a_seed_data = '0; a_rnd_ready = 1'b0;
        b_seed_valid = 1'b0; b_seed_data = '0; b_rnd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_valid", 32'(a_rnd_valid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd1);
        check("rst_seed_ready", 32'(a_seed_ready), 32'd0);
        check("rst_health", 32'(a_health), 32'd0);
        check("rst_word", 32'(a_rnd), 32'h068);

        // warm-up length with consumer always ready
        a_rnd_ready = 1'b1;
        rst = 1'b0;
        w = 0;
        busy_n = 0;
        while (a_rnd_valid !== 1'b1 && w < 200) begin
            if (a_busy === 1'b1) busy_n++;
            tick();
            w++;
        end
        a_rnd_ready = 1'b0;
        check("warmup_len", 32'(w), 32'd64);
        check("warmup_busy", 32'(busy_n), 32'd64);
        check("run_busy", 32'(a_busy), 32'd0);
        check("run_seed_ready", 32'(a_seed_ready), 32'd1);
        m_a = SEED_DEF;
        repeat (64) m_a = m_adv(m_a);
        check("warmup_word", 32'(a_rnd), 32'(m_a[8:0]));

        // back-pressure holds the word, then five back-to-back words
        held = a_rnd;
        chg = 0;
        repeat (10) begin
            tick();
            if (a_rnd !== held || a_rnd_valid !== 1'b1) chg++;
        end
        check("hold_stable", 32'(chg), 32'd0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(m_a[8:0]);
            m_a = m_adv(m_a);
        end
        a_rnd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e = exp_q.pop_front();
            check("burst_word", 32'(a_rnd), 32'(e));
            w5[i] = a_rnd;
            tick();
        end
        a_rnd_ready = 1'b0;
        same = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 5; j++) begin
                if (w5[i] == w5[j]) same++;
            end
        end
        check("burst_distinct", 32'(same), 32'd0);

        // zero warm-up, seed 1: hand-computed first two words
        seed_b(32'h1);
        check("seed1_word0", 32'(b_rnd), 32'h001);
        b_rnd_ready = 1'b1;
        tick();
        b_rnd_ready = 1'b0;
        check("seed1_word1", 32'(b_rnd), 32'h16D);
        m_b = m_adv(m_b);
        consume_b("seed1_seq", 20, 0);

        // seed 0 behaves exactly like the default seed
        seed_b(32'h0);
        consume_b("seed0_seq", 1000, 1);
        seed_b(SEED_DEF);
        consume_b("seeddef_seq", 1000, 2);
        same = 0;
        for (int i = 0; i < 1000; i++) begin
            if (cap0[i] !== cap1[i]) same++;
        end
        check("seed0_vs_default", 32'(same), 32'd0);

        // seed and rnd handshake collide: seed wins
        b_rnd_ready  = 1'b1;
        b_seed_valid = 1'b1;
        b_seed_data  = 32'h5;
        check("collide_pre", 32'(b_rnd_valid & b_seed_ready), 32'd1);
        tick();
        b_seed_valid = 1'b0;
        b_rnd_ready  = 1'b0;
        check("collide_valid", 32'(b_rnd_valid), 32'd0);
        check("collide_busy", 32'(b_busy), 32'd1);
        tick();
        check("collide_run", 32'(b_rnd_valid), 32'd1);
        check("collide_word", 32'(b_rnd), 32'h005);
        m_b = 32'h5;
        consume_b("seed5_seq", 5, 0);

`ifdef MASK_RNG_HEALTH_EN
        force dut0.lfsr_q = 32'h0000_1234;
        b_rnd_ready = 1'b1;
        repeat (3) tick();
        check("health_pre", 32'(b_health), 32'd0);
        check("health_pre_valid", 32'(b_rnd_valid), 32'd1);
        tick();
        b_rnd_ready = 1'b0;
        check("health_trip", 32'(b_health), 32'd1);
        check("halt_valid", 32'(b_rnd_valid), 32'd0);
        check("halt_seed_ready", 32'(b_seed_ready), 32'd1);
        release dut0.lfsr_q;
        seed_b(32'h5);
        check("health_reseed_word", 32'(b_rnd), 32'h005);
`else
        check("health_tied_b", 32'(b_health), 32'd0);
        check("health_tied_a", 32'(a_health), 32'd0);
`endif

        // asynchronous reset mid-run
        a_rnd_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(a_rnd_valid), 32'd0);
        check("async_rst_busy", 32'(a_busy), 32'd1);
        check("async_rst_word", 32'(a_rnd), 32'h068);
        check("async_rst_seed_ready", 32'(b_seed_ready), 32'd0);
        check("async_rst_health", 32'(b_health), 32'd0);
        a_rnd_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
